// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// No logic: state encoding and default width only.
// No handshake of its own.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: ai - bi - br.
// Purely combinational, zero latency.
// No handshake.
module full_subtractor (
    input  logic ai,
    input  logic bi,
    input  logic br,
    output logic diff,
    output logic borrow
);

    assign diff   = ai ^ bi ^ br;
    assign borrow = (~ai & bi) | (~(ai ^ bi) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock via a single cell.
// Latency: WIDTH cycles from the accepting edge to done; done lasts one cycle.
// start is ignored while busy; start held in DONE chains the next operation.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_d;
    logic             r_br;
    logic             r_bout;
    logic [CW-1:0]    r_count;

    logic             w_load;
    logic             w_last;
    logic             w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_acc_nxt;

    full_subtractor u_cell (
        .ai     (r_a[0]),
        .bi     (r_b[0]),
        .br     (r_br),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    assign w_load = start && (r_state != S_RUN);
    assign w_last = (r_count == CW'(WIDTH - 1));

    // Each new difference bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign w_acc_nxt = w_diff;
        end else begin : g_acc_wn
            assign w_acc_nxt = {w_diff, r_acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_d     <= '0;
            r_br    <= 1'b0;
            r_bout  <= 1'b0;
            r_count <= '0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_acc   <= w_acc_nxt;
            r_br    <= w_borrow;
            r_count <= r_count + 1'b1;
            // Results are published only on the final bit so d never shows a partial value.
            if (w_last) begin
                r_d    <= w_acc_nxt;
                r_bout <= w_borrow;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign d    = r_d;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 and WIDTH=1) and the full_subtractor cell.
// Expected results are queued at stimulus time and checked when done pulses.
// Timing of busy/done is checked against the accepting edge.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] d8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       bin1 = 1'b0;
    logic       busy1, done1, bout1;
    logic [0:0] d1;

    logic       fs_ai = 1'b0, fs_bi = 1'b0, fs_br = 1'b0;
    logic       fs_diff, fs_borrow;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [8:0] sb8[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1)
    );

    full_subtractor u_fs (
        .ai(fs_ai), .bi(fs_bi), .br(fs_br), .diff(fs_diff), .borrow(fs_borrow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {8'd0, bin};
    endfunction

    // Scoreboard: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (!rst && done8) begin
            chk("busy_done_exclusive", {31'd0, busy8}, 32'd0);
            if (sb8.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = sb8.pop_front();
                chk("sb_d", {24'd0, d8}, {24'd0, e[7:0]});
                chk("sb_bout", {31'd0, bout8}, {31'd0, e[8]});
            end
        end
    end

    // Samples #1 after each edge; returns edges until done (or limit) and RUN cycles seen.
    task automatic wait_done8(output int n, output int bc);
        n  = 0;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (done8) break;
            if (busy8) bc++;
        end
        if (!done8) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin);
        int n, bc;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        sb8.push_back(model8(a, b, bin));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        bin8 = 1'($urandom);
        chk({tag, "_busy_after_accept"}, {31'd0, busy8}, 32'd1);
        wait_done8(n, bc);
        chk({tag, "_latency"}, n, 32'd8);
        chk({tag, "_busy_cycles"}, bc + 1, 32'd8);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, {31'd0, done8}, 32'd0);
        chk({tag, "_back_to_idle"}, {31'd0, busy8}, 32'd0);
    endtask

    initial begin
        int n, bc, extra;
        logic [1:0] e1;
        logic [1:0] efs;

        #3;
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_d", {24'd0, d8}, 32'd0);
        chk("rst_bout", {31'd0, bout8}, 32'd0);
        chk("rst_w1_busy", {31'd0, busy1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            fs_ai = v[2]; fs_bi = v[1]; fs_br = v[0];
            #1;
            efs = 2'({1'b0, fs_ai} - {1'b0, fs_bi} - {1'b0, fs_br});
            chk($sformatf("fs_diff_%0d", i), {31'd0, fs_diff}, {31'd0, efs[0]});
            chk($sformatf("fs_borrow_%0d", i), {31'd0, fs_borrow}, {31'd0, efs[1]});
        end

        run8("t200m55", 8'd200, 8'd55, 1'b0);
        run8("t5m9", 8'd5, 8'd9, 1'b0);
        run8("eq_bin1", 8'hA5, 8'hA5, 1'b1);
        run8("eq_bin0", 8'h3C, 8'h3C, 1'b0);
        run8("t255m0", 8'hFF, 8'h00, 1'b1);

        // start re-pulsed mid-run must be ignored
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd30; bin8 = 1'b0; start8 = 1'b1;
        sb8.push_back(model8(8'd100, 8'd30, 1'b0));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 8'd7; b8 = 8'd99; bin8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done8(n, bc);
        chk("restart_latency", n + 4, 32'd8);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) extra++;
        end
        chk("restart_no_extra_op", extra, 32'd0);

        // reset in the middle of a run
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd20; bin8 = 1'b1; start8 = 1'b1;
        sb8.push_back(model8(8'd50, 8'd20, 1'b1));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy8}, 32'd0);
        chk("midrst_done", {31'd0, done8}, 32'd0);
        chk("midrst_d", {24'd0, d8}, 32'd0);
        chk("midrst_bout", {31'd0, bout8}, 32'd0);
        void'(sb8.pop_back());
        @(negedge clk);
        rst = 1'b0;
        run8("after_rst", 8'd50, 8'd20, 1'b1);

        // back-to-back with start held through DONE
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0; start8 = 1'b1;
        sb8.push_back(model8(8'h10, 8'h20, 1'b0));
        @(posedge clk);
        #1;
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b1;
        sb8.push_back(model8(8'h80, 8'h01, 1'b1));
        wait_done8(n, bc);
        chk("b2b_first_latency", n, 32'd8);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (i == 0) begin
                chk("b2b_no_idle", {31'd0, busy8}, 32'd1);
                start8 = 1'b0;
            end
            if (done8) break;
        end
        chk("b2b_gap", n, 32'd9);
        repeat (2) @(posedge clk);
        chk("sb_empty", sb8.size(), 32'd0);

        // WIDTH=1 instance
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; start1 = 1'b1;
        e1 = {1'b0, a1} - {1'b0, b1} - {1'b0, bin1};
        @(posedge clk);
        #1;
        start1 = 1'b0;
        chk("w1_busy", {31'd0, busy1}, 32'd1);
        @(posedge clk);
        #1;
        chk("w1_done", {31'd0, done1}, 32'd1);
        chk("w1_d", {31'd0, d1}, {31'd0, e1[0]});
        chk("w1_bout", {31'd0, bout1}, {31'd0, e1[1]});
        @(posedge clk);
        #1;
        chk("w1_done_one_cycle", {31'd0, done1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
